rd_packer: RTL and testbench
============================

RD_PACKER -- requirements
Module: rd_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of one FIFO read word (byte lane).
REQ-002 SHALL have parameter LANES, default 4: number of FIFO words packed into one output word; LANES >= 2.
REQ-003 SHALL have port rclk, input, 1: the single clock, which is the FIFO read-side clock.
REQ-004 SHALL have port rrst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port rempty, input, 1: FIFO empty flag.
REQ-006 SHALL have port rdata, input, WIDTH: FIFO read data, valid the cycle after a rinc pulse.
REQ-007 SHALL have port rinc, output, 1: FIFO pop request.
REQ-008 SHALL have port out_data, output, WIDTH*LANES: packed word.
REQ-009 SHALL have port out_keep, output, LANES: per-lane valid mask.
REQ-010 SHALL have port out_valid, output, 1: packed word available.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts.
REQ-012 SHALL have port word_cnt, output, 16: count of accepted output words, wrapping.
REQ-013 SHALL have port flush, input, 1: only present when RD_PACKER_FLUSH_EN is defined.

Function
REQ-014 SHALL implement a two-state FSM: FILL (collecting) and HOLD (out_valid=1).
REQ-015 SHALL track cnt (0..LANES, captured lanes) and pend (1 when a pop was issued last cycle).
REQ-016 SHALL drive rinc = (state==FILL) && !rempty && (cnt+pend < LANES) && !rrst, combinationally; no other pops permitted.
REQ-017 SHALL capture rdata into lane cnt (lane 0 = bits [WIDTH-1:0], first popped) whenever pend=1, then increment cnt.
REQ-018 SHALL transition FILL->HOLD on the edge where the capture makes cnt==LANES, with out_keep all ones.
REQ-019 SHALL hold out_data/out_keep stable and out_valid high in HOLD until out_ready=1.
REQ-020 SHALL, on out_valid && out_ready, return to FILL with cnt=0 and increment word_cnt (0xFFFF wraps to 0x0000).
REQ-021 SHALL never pop while in HOLD; back-pressure therefore propagates to the FIFO.
REQ-022 SHALL achieve unstalled throughput of one packed word per LANES+2 cycles, with the first pop to out_valid taking LANES+1 cycles.
REQ-023 SHALL tolerate rempty toggling mid-word: a partial word is kept, and collection resumes when data arrives.
REQ-024 SHALL hold out_data lanes not yet written, and lanes outside out_keep, at zero.

Reset
REQ-025 SHALL, on rrst=1 at a rclk edge, set state=FILL, cnt=0, pend=0, out_data=0, out_keep=0, out_valid=0, word_cnt=0, and clear any pending flush.
REQ-026 SHALL force rinc=0 while rrst=1; any partial word or in-flight pop is discarded on reset, including mid-HOLD.

Configuration
REQ-027 SHALL, when macro RD_PACKER_FLUSH_EN is defined, provide the flush port; a flush=1 pulse sets flush_pend, which blocks new pops.
REQ-028 SHALL, once flush_pend=1 and pend=0: if cnt>0, enter HOLD with out_keep = low cnt bits set; if cnt==0, just clear flush_pend; flush_pend clears when HOLD is entered.
REQ-029 SHALL ignore a flush received during HOLD, except that it is latched and applied after the handshake.
REQ-030 SHALL, without RD_PACKER_FLUSH_EN, omit the flush port and logic; out_keep is then all ones whenever out_valid=1.

Structure
REQ-031 SHALL place the FSM state enum (FILL, HOLD) and the word_cnt width constant (16) in shared package rd_packer_pkg.
REQ-032 SHALL have no sub-module; lane steering is inline.

Verification
REQ-033 SHALL cover reset: rrst=1 for 2 cycles -> rinc=0, out_valid=0, word_cnt=0, out_keep=0.
REQ-034 SHALL cover back-to-back packing: FIFO holds 0x11,0x22,0x33,0x44 with out_ready=1 -> out_data=0x44332211, out_keep=0xF, out_valid 5 cycles after the first rinc, word_cnt=1.
REQ-035 SHALL cover back-pressure: 8 bytes 0x01..0x08 with out_ready=0 for 10 cycles -> rinc stays 0 in HOLD, out_data stable at 0x04030201, then 0x08070605 follows; word_cnt=2.
REQ-036 SHALL cover underflow stall: 2 bytes, then rempty=1 for 6 cycles, then 2 bytes -> no out_valid until the 4th byte, and no rinc while rempty=1.
REQ-037 SHALL cover flush with the macro defined: 3 bytes 0xA1,0xA2,0xA3 then flush -> out_data=0x00A3A2A1, out_keep=0x7; a flush with cnt=0 produces no output.
REQ-038 SHALL cover mid-word reset: rrst after 2 captured bytes, then 4 bytes 0x5..0x8 -> out_data=0x08070605, with no stale lanes.

Source files
------------

// File: rtl/rd_packer_pkg.sv
// rd_packer_pkg
//   Shared definitions for the rd_packer block.
//   state_t    : packer FSM state (FILL = collecting lanes, HOLD = word offered)
//   WORD_CNT_W : width of the accepted-word counter
package rd_packer_pkg;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam int WORD_CNT_W = 16;

endpackage

// File: rtl/rd_packer.sv
// rd_packer
//   Pops WIDTH-bit words from a FIFO read port and packs LANES of them into
//   one WIDTH*LANES output word.
//   Lane 0 occupies the low bits and holds the first word popped.
//
//   Handshakes:
//     FIFO side : rinc is a pop request. rdata is valid the cycle after rinc.
//                 rinc is never raised while rempty=1.
//     Out side  : out_valid/out_ready. A word transfers on a cycle where both are high.
//                 While out_valid=1 and out_ready=0, out_data and out_keep hold their values.
//                 out_valid does not drop until the word transfers.
//
//   Ports
//     rclk      : clock (FIFO read-side clock)
//     rrst      : synchronous active-high reset
//     rempty    : FIFO empty flag
//     rdata     : FIFO read data
//     rinc      : FIFO pop request
//     out_data  : packed word
//     out_keep  : per-lane valid mask
//     out_valid : packed word available
//     out_ready : consumer accepts
//     word_cnt  : count of accepted words, wraps at 16 bits
//     flush     : only when RD_PACKER_FLUSH_EN is defined. Emits a partial word.
//
//   Optional feature macro: RD_PACKER_FLUSH_EN
module rd_packer
   import rd_packer_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LANES = 4
) (
   input  logic                   rclk,
   input  logic                   rrst,
   input  logic                   rempty,
   input  logic [WIDTH-1:0]       rdata,
   output logic                   rinc,
   output logic [WIDTH*LANES-1:0] out_data,
   output logic [LANES-1:0]       out_keep,
   output logic                   out_valid,
   input  logic                   out_ready,
`ifdef RD_PACKER_FLUSH_EN
   input  logic                   flush,
`endif
   output logic [WORD_CNT_W-1:0]  word_cnt
);

   localparam int CNT_W = $clog2(LANES + 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             pend;
   logic [CNT_W:0]   inflight;
   logic             room;
   logic             full_now;
   logic             handshake;
   logic             flush_go;
   logic             block_pop;

   // Captured lanes plus a pop still in flight.
   // This total must stay within LANES so that no popped word is lost.
   assign inflight  = {1'b0, cnt} + {{CNT_W{1'b0}}, pend};
   assign room      = inflight < (CNT_W + 1)'(LANES);
   assign full_now  = pend && (cnt == CNT_W'(LANES - 1));
   assign handshake = (state == HOLD) && out_ready;
   assign out_valid = (state == HOLD);

`ifdef RD_PACKER_FLUSH_EN
   logic flush_pend;
   logic flush_drop;

   // A flush waits for any in-flight pop to land before it acts.
   // It acts only in FILL, so a flush received in HOLD is applied after the handshake.
   assign flush_go   = (state == FILL) && flush_pend && !pend && (cnt != '0);
   assign flush_drop = (state == FILL) && flush_pend && !pend && (cnt == '0);
   assign block_pop  = flush_pend;

   always_ff @(posedge rclk) begin
      if (rrst) begin
         flush_pend <= 1'b0;
      end else if (flush) begin
         flush_pend <= 1'b1;
      end else if (((state == FILL) && (state_nxt == HOLD)) || flush_drop) begin
         flush_pend <= 1'b0;
      end
   end
`else
   assign flush_go  = 1'b0;
   assign block_pop = 1'b0;
`endif

   assign rinc = (state == FILL) && !rempty && room && !block_pop && !rrst;

   always_ff @(posedge rclk) begin
      if (rrst) begin
         state <= FILL;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FILL:    if (full_now || flush_go) state_nxt = HOLD;
         HOLD:    if (out_ready) state_nxt = FILL;
         default: state_nxt = FILL;
      endcase
   end

   // In HOLD, pend is always 0.
   // The pop that fills the last lane is the final pop allowed before HOLD.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         cnt      <= '0;
         pend     <= 1'b0;
         out_data <= '0;
         out_keep <= '0;
         word_cnt <= '0;
      end else begin
         pend <= rinc;
         if (handshake) begin
            // Clearing out_data keeps lanes that are not yet written at zero for the next word.
            cnt      <= '0;
            out_data <= '0;
            out_keep <= '0;
            word_cnt <= word_cnt + WORD_CNT_W'(1);
         end else if (pend) begin
            for (int i = 0; i < LANES; i++) begin
               if (cnt == CNT_W'(i)) out_data[i*WIDTH +: WIDTH] <= rdata;
            end
            cnt <= cnt + CNT_W'(1);
            if (full_now) out_keep <= '1;
         end else if (flush_go) begin
            for (int i = 0; i < LANES; i++) begin
               out_keep[i] <= (CNT_W'(i) < cnt);
            end
         end
      end
   end

endmodule

// File: tb/tb_rd_packer.sv
// tb_rd_packer
//   Self-checking bench for rd_packer (WIDTH=8, LANES=4).
//   A FIFO model feeds rdata one cycle after each rinc.
//   Expected packed words are built by grouping the pushed bytes four at a time.
//   Flush cases run only when RD_PACKER_FLUSH_EN is defined.
module tb_rd_packer;

   localparam int WIDTH = 8;
   localparam int LANES = 4;
   localparam int DW    = WIDTH * LANES;
   localparam int W     = DW + LANES;

   logic             rclk = 1'b0;
   logic             rrst;
   logic             rempty;
   logic [WIDTH-1:0] rdata;
   logic             rinc;
   logic [DW-1:0]    out_data;
   logic [LANES-1:0] out_keep;
   logic             out_valid;
   logic             out_ready;
   logic             flush;
   logic [15:0]      word_cnt;

   rd_packer #(.WIDTH(WIDTH), .LANES(LANES)) dut (
      .rclk      (rclk),
      .rrst      (rrst),
      .rempty    (rempty),
      .rdata     (rdata),
      .rinc      (rinc),
      .out_data  (out_data),
      .out_keep  (out_keep),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef RD_PACKER_FLUSH_EN
      .flush     (flush),
`endif
      .word_cnt  (word_cnt)
   );

   // clock
   always #5 rclk = ~rclk;

   // counters and scoreboard
   int           n_checks = 0;
   int           n_pass   = 0;
   int           viol     = 0;
   logic [W-1:0] exp_q[$];
   logic [7:0]   fifo_q[$];
   logic         stall = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // The FIFO model pops on the edge where rinc is high. The data appears on rdata for the next cycle.
   always @(posedge rclk) begin
      if (rinc) begin
         if (fifo_q.size() > 0) rdata <= fifo_q.pop_front();
         else viol++;
      end
   end

   // Output monitor and protocol watch. Sampled mid-cycle.
   logic         prev_hold = 1'b0;
   logic [W-1:0] prev_word = '0;
   always @(negedge rclk) begin
      logic [W-1:0] e;
      if (rrst) begin
         if (rinc) viol++;
         prev_hold = 1'b0;
      end else begin
         if (rinc && (rempty || out_valid)) viol++;
         if (prev_hold && (!out_valid || ({out_keep, out_data} != prev_word))) viol++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_word: got 0x%0h, none expected", {out_keep, out_data});
            end else begin
               e = exp_q.pop_front();
               check("packed_word", 64'({out_keep, out_data}), 64'(e));
            end
         end
         prev_hold = out_valid && !out_ready;
         prev_word = {out_keep, out_data};
      end
   end

   // driver tasks
   task automatic upd();
      rempty = stall || (fifo_q.size() == 0);
   endtask

   task automatic next();
      @(posedge rclk);
      #1;
      upd();
   endtask

   task automatic push(input logic [7:0] b);
      fifo_q.push_back(b);
      upd();
   endtask

   task automatic do_reset();
      rrst = 1'b1;
      fifo_q.delete();
      upd();
      next();
      next();
      rrst = 1'b0;
   endtask

   task automatic drain(input string name, input int limit);
      for (int i = 0; i < limit && exp_q.size() != 0; i++) next();
      check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
   endtask

   typedef struct {
      logic [7:0]    b0, b1, b2, b3;
      logic [DW-1:0] exp_data;
   } vec_t;

   vec_t       vecs[4];
   logic [7:0] src_q[$];

   initial begin
      int c0, c1;
      logic [7:0] rb[4];

      vecs[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h44332211};
      vecs[1] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hEFBEADDE};
      vecs[2] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 32'hFF00FF00};
      vecs[3] = '{8'h80, 8'h01, 8'h7F, 8'hFE, 32'hFE7F0180};

      rrst = 1'b1; out_ready = 1'b0; flush = 1'b0; rdata = '0; rempty = 1'b1;

      // Reset state. The FIFO holds a byte, so a pop would be possible if reset did not block it.
      push(8'h99);
      next();
      next();
      @(negedge rclk);
      check("reset_rinc", 64'(rinc), 64'd0);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_word_cnt", 64'(word_cnt), 64'd0);
      check("reset_out_keep", 64'(out_keep), 64'd0);
      check("reset_out_data", 64'(out_data), 64'd0);
      next();
      do_reset();

      // Back-to-back packing: latency from the first pop to out_valid.
      out_ready = 1'b1;
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      exp_q.push_back({4'hF, 32'h44332211});
      c0 = -1; c1 = -1;
      for (int t = 0; t < 20; t++) begin
         @(negedge rclk);
         if (rinc && c0 < 0) c0 = t;
         if (out_valid) begin c1 = t; break; end
         next();
      end
      check("first_pop_to_valid", 64'(c1 - c0), 64'd5);
      drain("b2b", 20);
      check("b2b_word_cnt", 64'(word_cnt), 64'd1);

      // Table-driven vectors, streamed back to back.
      do_reset();
      out_ready = 1'b1;
      for (int v = 0; v < 4; v++) begin
         push(vecs[v].b0); push(vecs[v].b1); push(vecs[v].b2); push(vecs[v].b3);
         exp_q.push_back({4'hF, vecs[v].exp_data});
      end
      drain("table", 100);
      check("table_word_cnt", 64'(word_cnt), 64'd4);

      // Back-pressure: the first word must hold and no pops may occur while it waits.
      do_reset();
      out_ready = 1'b0;
      for (int i = 1; i <= 8; i++) push(8'(i));
      exp_q.push_back({4'hF, 32'h04030201});
      exp_q.push_back({4'hF, 32'h08070605});
      for (int t = 0; t < 30 && !out_valid; t++) next();
      check("bp_valid", 64'(out_valid), 64'd1);
      for (int k = 0; k < 10; k++) begin
         @(negedge rclk);
         check("bp_hold_data", 64'(out_data), 64'h04030201);
         check("bp_no_pop", 64'(rinc), 64'd0);
         next();
      end
      out_ready = 1'b1;
      drain("bp", 40);
      check("bp_word_cnt", 64'(word_cnt), 64'd2);

      // Underflow stall: a partial word is held while the FIFO is empty.
      do_reset();
      out_ready = 1'b1;
      push(8'h31); push(8'h32);
      exp_q.push_back({4'hF, 32'h34333231});
      for (int k = 0; k < 4; k++) next();
      for (int k = 0; k < 6; k++) begin
         @(negedge rclk);
         check("uf_no_valid", 64'(out_valid), 64'd0);
         check("uf_no_pop", 64'(rinc), 64'd0);
         next();
      end
      push(8'h33); push(8'h34);
      drain("uf", 30);

      // Mid-word reset: the two captured bytes must not leak into the next word.
      do_reset();
      out_ready = 1'b1;
      push(8'hEE); push(8'hDD);
      for (int k = 0; k < 4; k++) next();
      rrst = 1'b1;
      next();
      rrst = 1'b0;
      for (int i = 5; i <= 8; i++) push(8'(i));
      exp_q.push_back({4'hF, 32'h08070605});
      drain("midrst", 30);
      check("midrst_word_cnt", 64'(word_cnt), 64'd1);

`ifdef RD_PACKER_FLUSH_EN
      // Flush of a partial word, then a flush when no lanes are captured.
      do_reset();
      out_ready = 1'b1;
      push(8'hA1); push(8'hA2); push(8'hA3);
      exp_q.push_back({4'h7, 32'h00A3A2A1});
      for (int k = 0; k < 6; k++) next();
      flush = 1'b1;
      next();
      flush = 1'b0;
      drain("flush", 20);
      flush = 1'b1;
      next();
      flush = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge rclk);
         check("flush_empty_no_valid", 64'(out_valid), 64'd0);
         next();
      end
      check("flush_word_cnt", 64'(word_cnt), 64'd1);
`endif

      // Randomized traffic checked against the byte-grouping reference.
      do_reset();
      for (int w = 0; w < 24; w++) begin
         for (int l = 0; l < LANES; l++) begin
            rb[l] = 8'($urandom_range(0, 255));
            src_q.push_back(rb[l]);
         end
         exp_q.push_back({4'hF, rb[3], rb[2], rb[1], rb[0]});
      end
      for (int c = 0; c < 4000 && exp_q.size() != 0; c++) begin
         if (src_q.size() > 0 && $urandom_range(0, 2) != 0) fifo_q.push_back(src_q.pop_front());
         stall     = ($urandom_range(0, 4) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         next();
      end
      stall = 1'b0;
      out_ready = 1'b1;
      next();
      check("rand_drained", 64'(exp_q.size()), 64'd0);
      check("rand_word_cnt", 64'(word_cnt), 64'd24);
      check("rand_fifo_empty", 64'(fifo_q.size()), 64'd0);

      for (int k = 0; k < 4; k++) next();
      check("protocol_violations", 64'(viol), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
